alu_seq_ctrl: RTL and testbench

//  Multi-cycle operation sequencer sitting directly upstream of the 9-bit add/sub stage.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_seq_step.sv | 36 +++
 rtl/alu_seq_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the add/sub/mul/div sequencer: opcodes, FSM encoding, widths.
package alu_pkg;
  localparam int ALU_WIDTH = 8;
  localparam int ALU_CNT_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDSUB = 3'd1,
    ST_MUL    = 3'd2,
    ST_DIV    = 3'd3,
    ST_ERR    = 3'd4,
    ST_FIN    = 3'd5
  } state_t;
endpackage

// File: rtl/alu_seq_step.sv
// Per-step next-value logic for the iterative ops: Booth ASR for MUL, shift/restore for DIV.
// The divide branch exists only when ALU_SEQ_DIV_EN is defined.
module alu_seq_step
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   add_z,
  output logic [WIDTH:0]   a_nxt,
  output logic [WIDTH-1:0] q_nxt,
  output logic             qm1_nxt
);

  always_comb begin
    a_nxt   = {add_z[WIDTH], add_z[WIDTH:1]};
    q_nxt   = {add_z[0], q[WIDTH-1:1]};
    qm1_nxt = q[0];
`ifdef ALU_SEQ_DIV_EN
    if (is_div) begin
      // A negative trial difference means the divisor did not fit: keep the shifted remainder
      a_nxt   = add_z[WIDTH] ? {a[WIDTH-1:0], q[WIDTH-1]} : add_z;
      q_nxt   = {q[WIDTH-2:0], ~add_z[WIDTH]};
      qm1_nxt = 1'b0;
    end
`endif
  end

`ifndef ALU_SEQ_DIV_EN
  logic unused_div;
  assign unused_div = ^{is_div, a};
`endif

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer driving an external 9-bit add/sub stage for ADD/SUB/MUL/DIV.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise op=11 reports an error.
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_ADDSUB | single adder pass for ADD/SUB
// ST_MUL    | Booth radix-2 step, cnt = 0..WIDTH-1
// ST_DIV    | restoring divide step, cnt = 0..WIDTH-1
// ST_ERR    | unsupported op or divide by zero
// ST_FIN    | register result/flags, pulse done
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = ALU_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic [WIDTH:0]     add_x,
  output logic [WIDTH:0]     add_y,
  output logic               add_sel,
  input  logic [WIDTH:0]     add_z,
  input  logic               add_ovf,
  input  logic               add_neg,
  input  logic               add_zero,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               ovf,
  output logic               neg,
  output logic               zero,
  output logic               carry,
  output logic               err
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     a, m;
  logic [WIDTH-1:0]   q;
  logic               qm1;
  logic [1:0]         op_q;
  logic               err_q;
  logic [2:0]         fl_q;
  logic [WIDTH:0]     a_nxt;
  logic [WIDTH-1:0]   q_nxt;
  logic               qm1_nxt;
  logic [2*WIDTH-1:0] prod;

  assign prod = {a[WIDTH-1:0], q};

  alu_seq_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (state == ST_DIV),
    .a       (a),
    .q       (q),
    .add_z   (add_z),
    .a_nxt   (a_nxt),
    .q_nxt   (q_nxt),
    .qm1_nxt (qm1_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_ADD, OP_SUB: state_nxt = ST_ADDSUB;
            OP_MUL:         state_nxt = ST_MUL;
`ifdef ALU_SEQ_DIV_EN
            default:        state_nxt = (opb == '0) ? ST_ERR : ST_DIV;
`else
            default:        state_nxt = ST_ERR;
`endif
          endcase
        end
      end
      ST_MUL, ST_DIV: if (cnt == CNT_W'(WIDTH-1)) state_nxt = ST_FIN;
      ST_ADDSUB, ST_ERR: state_nxt = ST_FIN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    add_x   = '0;
    add_y   = '0;
    add_sel = 1'b0;
    busy    = (state != ST_IDLE);
    case (state)
      ST_ADDSUB: begin
        add_x   = {1'b0, q};
        add_y   = m;
        add_sel = (op_q == OP_SUB);
      end
      ST_MUL: begin
        add_x = a;
        if (q[0] != qm1) begin
          add_y   = m;
          add_sel = q[0];
        end
      end
`ifdef ALU_SEQ_DIV_EN
      ST_DIV: begin
        add_x   = {a[WIDTH-1:0], q[WIDTH-1]};
        add_y   = m;
        add_sel = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a      <= '0;
      m      <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      op_q   <= OP_ADD;
      err_q  <= 1'b0;
      fl_q   <= '0;
      done   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
      zero   <= 1'b0;
      carry  <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= (state == ST_FIN);
      case (state)
        ST_IDLE: if (start) begin
          op_q  <= op;
          q     <= opa;
          a     <= '0;
          qm1   <= 1'b0;
          cnt   <= '0;
          m     <= (op == OP_MUL) ? {opb[WIDTH-1], opb} : {1'b0, opb};
          err_q <= (state_nxt == ST_ERR);
        end
        ST_ADDSUB: begin
          a    <= add_z;
          fl_q <= {add_ovf, add_neg, add_zero};
        end
        ST_MUL, ST_DIV: begin
          a   <= a_nxt;
          q   <= q_nxt;
          qm1 <= qm1_nxt;
          cnt <= cnt + 1'b1;
        end
        ST_FIN: begin
          ovf   <= 1'b0;
          neg   <= 1'b0;
          zero  <= 1'b0;
          carry <= 1'b0;
          err   <= 1'b0;
          if (err_q) begin
`ifdef ALU_SEQ_DIV_EN
            result <= {q, {WIDTH{1'b1}}};
`else
            result <= '0;
`endif
            err <= 1'b1;
          end else if (op_q == OP_MUL) begin
            result <= prod;
            neg    <= prod[2*WIDTH-1];
            zero   <= (prod == '0);
          end else if (op_q == OP_DIV) begin
            result <= prod;
            zero   <= (q == '0);
          end else begin
            result <= {{WIDTH{1'b0}}, a[WIDTH-1:0]};
            carry  <= a[WIDTH];
            {ovf, neg, zero} <= fl_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 9-bit add/sub stage.
// DIV vectors follow ALU_SEQ_DIV_EN; without it, op=11 must report an error.
module tb_alu_seq_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [7:0]  opa = '0, opb = '0;
  logic [8:0]  add_x, add_y, add_z, y_eff;
  logic        add_sel, add_ovf, add_neg, add_zero;
  logic        busy, done, ovf, neg, zero, carry, err;
  logic [15:0] result;

  int n_chk = 0;
  int n_pass = 0;
  int lat;
  int done_cnt;

  always #5 clk = ~clk;

  assign y_eff    = add_sel ? ~add_y : add_y;
  assign add_z    = add_x + y_eff + {8'b0, add_sel};
  assign add_neg  = add_z[7];
  assign add_zero = (add_z[7:0] == 8'h00);
  assign add_ovf  = (add_x[7] == y_eff[7]) && (add_z[7] != add_x[7]);

  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .add_x(add_x), .add_y(add_y), .add_sel(add_sel), .add_z(add_z),
    .add_ovf(add_ovf), .add_neg(add_neg), .add_zero(add_zero),
    .busy(busy), .done(done), .result(result),
    .ovf(ovf), .neg(neg), .zero(zero), .carry(carry), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Issues one request and waits for done; poke > 0 re-asserts start that many edges after accept.
  task automatic run(input logic [1:0] o, input logic [7:0] a, input logic [7:0] b, input int poke);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == poke) begin
        start = 1'b1; op = OP_ADD; opa = 8'h01; opb = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 16'h0000);
    chk("rst_flags", {ovf, neg, zero, carry, err}, 5'b0);
    chk("rst_adder_x", add_x, 9'h000);
    rst = 1'b0;
    @(posedge clk); #1;

    run(OP_ADD, 8'd79, 8'd48, 0);
    chk("add_lat", lat, 2);
    chk("add_res", result, 16'h007F);
    chk("add_carry", carry, 0);
    chk("add_ovf", ovf, 0);
    chk("add_busy_on_done", busy, 0);

    // issued in the done cycle of the previous op
    run(OP_SUB, 8'd8, 8'd16, 0);
    chk("sub_lat", lat, 2);
    chk("sub_res", result, 16'h00F8);
    chk("sub_neg", neg, 1);
    chk("sub_carry", carry, 1);

    run(OP_ADD, 8'h7F, 8'h01, 0);
    chk("add_ovf_res", result, 16'h0080);
    chk("add_ovf_flag", ovf, 1);

    run(OP_MUL, 8'hFD, 8'h07, 0);
    chk("mul_lat", lat, 9);
    chk("mul_neg3x7", result, 16'hFFEB);
    chk("mul_neg3x7_neg", neg, 1);

    run(OP_MUL, 8'h80, 8'h80, 0);
    chk("mul_m128sq", result, 16'h4000);
    chk("mul_m128sq_neg", neg, 0);

    run(OP_MUL, 8'h00, 8'h5A, 0);
    chk("mul_zero", result, 16'h0000);
    chk("mul_zero_flag", zero, 1);

    run(OP_MUL, 8'h7F, 8'h7F, 0);
    chk("mul_127sq", result, 16'h3F01);

    run(OP_MUL, 8'h05, 8'hFE, 0);
    chk("mul_5xneg2", result, 16'hFFF6);
    chk("mul_err", err, 0);

`ifdef ALU_SEQ_DIV_EN
    run(OP_DIV, 8'd200, 8'd7, 0);
    chk("div_lat", lat, 9);
    chk("div_200_7", result, 16'h041C);
    chk("div_200_7_zero", zero, 0);

    run(OP_DIV, 8'd7, 8'd200, 0);
    chk("div_7_200", result, 16'h0700);
    chk("div_7_200_zero", zero, 1);

    run(OP_DIV, 8'h33, 8'h00, 0);
    chk("div0_lat", lat, 2);
    chk("div0_res", result, 16'h33FF);
    chk("div0_err", err, 1);
`else
    run(OP_DIV, 8'h64, 8'h05, 0);
    chk("nodiv_lat", lat, 2);
    chk("nodiv_res", result, 16'h0000);
    chk("nodiv_err", err, 1);

    run(OP_DIV, 8'h33, 8'h00, 0);
    chk("nodiv0_res", result, 16'h0000);
    chk("nodiv0_err", err, 1);
`endif

    run(OP_MUL, 8'h03, 8'h04, 3);
    chk("ign_lat", lat, 9);
    chk("ign_res", result, 16'h000C);
    chk("ign_err_clr", err, 0);
    done_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done || busy) done_cnt++;
    end
    chk("ign_no_second_op", done_cnt, 0);

    op = OP_MUL; opa = 8'h12; opb = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 16'h0000);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);

    run(OP_ADD, 8'h05, 8'h03, 0);
    chk("post_rst_res", result, 16'h0008);
    chk("post_rst_lat", lat, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
